// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, registered sync/blank/frame strobes.
// Derived outputs are computed from next-state counters so they line up with pixel_x/pixel_y every cycle.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 2,
  parameter int SYNC_POL  = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] X_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             SYNC_ACT = 1'(SYNC_POL);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;
  logic             x_wrap, y_wrap;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
    p_tick_d  = (div_cnt_q == DIV_MAX);

    x_wrap = p_tick_q && (pixel_x_q == X_MAX);
    y_wrap = x_wrap && (pixel_y_q == Y_MAX);

    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (p_tick_q) begin
      pixel_x_d = x_wrap ? '0 : pixel_x_q + 1'b1;
      if (x_wrap) begin
        pixel_y_d = y_wrap ? '0 : pixel_y_q + 1'b1;
      end
    end

    // Decode from the next-state counters so the registered flags match the coordinates they accompany.
    hsync_d       = ((pixel_x_d >= HS_FIRST) && (pixel_x_d <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d       = ((pixel_y_d >= VS_FIRST) && (pixel_y_d <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    video_on_d    = (pixel_x_d < X_VIS) && (pixel_y_d < Y_VIS);
    frame_start_d = y_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      p_tick_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      p_tick_q      <= p_tick_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Raster timing generator for the 640x480@60 Hz VGA path. Sits directly upstream of the vga pixel/colour stage.
- Divides the system clock down to a pixel tick and runs horizontal and vertical counters.
- Produces hsync, vsync, video_on, the current pixel coordinates and a frame-start strobe.
- The colour stage uses these to drive rgb from sw.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 2, clk cycles per pixel; must be >= 1
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CNT_W, 10, width of pixel_x/pixel_y

Ports:
- clk  in  1  system clock (50 MHz); the only clock
- reset  in  1  synchronous, active-high reset
- p_tick  out  1  one-clk pulse per pixel period
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  high when (pixel_x, pixel_y) is in the visible area
- pixel_x  out  CNT_W  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  CNT_W  current vertical count, 0..V_TOTAL-1
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state clears on the clk edge where reset=1.
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
- Reset values:
  - divider = 0, p_tick = 0
  - pixel_x = 0, pixel_y = 0
  - video_on = 1
  - hsync = vsync = ~SYNC_POL (inactive)
  - frame_start = 0
- Tick divider:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - p_tick is registered: high for exactly one clk on the cycle after div_cnt = TICK_DIV-1.
  - With TICK_DIV=1, p_tick stays high continuously after the first post-reset cycle.
  - First p_tick occurs TICK_DIV clks after reset deasserts.
- Counters (advance only on an edge where p_tick=1):
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - pixel_y increments only when pixel_x wraps, and wraps from V_TOTAL-1 to 0 at that same edge.
  - Counter values never leave their ranges.
- Derived outputs (hsync, vsync, video_on):
  - Registered, computed from next-state counter values, so on any cycle they are consistent with the pixel_x/pixel_y presented on that cycle. Zero relative latency.
  - hsync active iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (default 656..751).
  - vsync active iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (default 490..491).
  - video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY).
- frame_start:
  - High for one clk, on the cycle where pixel_x and pixel_y have both just become 0 by wrap.
  - Not asserted by reset itself.
- Reset mid-frame: on the next edge all outputs take reset values regardless of divider phase. Counting restarts cleanly from (0,0) with full divider period.
- Reset has priority over the tick when both occur on the same edge.
- Output widths: CNT_W must hold H_TOTAL-1 and V_TOTAL-1. Upper bits are zero-extended.

Test Plan:
- Reset held 3 clks then released -> during/after reset pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=1, p_tick=0, frame_start=0; first p_tick 2 clks after release.
- Free run one line (800 ticks = 1600 clks) -> video_on falls when pixel_x goes 639->640; hsync low for exactly 96 ticks at x=656..751; pixel_x wraps 799->0 and pixel_y 0->1 on the same edge.
- Free run one frame (525 lines, 840000 clks) -> vsync low exactly for lines 490..491 (1600 ticks); video_on low for all of lines 480..524; frame_start pulses once, exactly at the wrap 799/524 -> 0/0; hsync period 1600 clks throughout.
- Assert reset for 1 clk at pixel (300, 200) with div_cnt=1 -> next cycle all outputs at reset values; subsequent timing identical to the post-reset case.
- Parameter override TICK_DIV=1, H_DISPLAY=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> line = 12 clks, frame = 84 clks; hsync active at x=9..10; vsync active at y=5; frame_start every 84 clks.
- Scoreboard check over 2 full frames -> video_on, hsync, vsync match the reference equations on the same-cycle pixel_x/pixel_y at every clk (zero mismatch).
